// File: rtl/pg_pkg.sv
// Shared types and constants for the digit-serial PG adder.
package pg_pkg;

  localparam int DIGIT_W = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/pg_slice2.sv
// Combinational 2-bit propagate/generate slice: sum digit, ripple carry, digit P/G.
module pg_slice2
  import pg_pkg::*;
(
  input  logic [DIGIT_W-1:0] a,
  input  logic [DIGIT_W-1:0] b,
  input  logic               c,
  output logic [DIGIT_W-1:0] s,
  output logic               c2,
  output logic               dp,
  output logic               dg
);

  logic [DIGIT_W-1:0] p;
  logic [DIGIT_W-1:0] g;
  logic               c1;

  assign p  = a ^ b;
  assign g  = a & b;
  assign c1 = g[0] | (p[0] & c);
  assign s  = {p[1] ^ c1, p[0] ^ c};
  assign c2 = g[1] | (p[1] & c1);
  assign dp = p[1] & p[0];
  // Digit generate must not depend on the incoming carry.
  assign dg = g[1] | (p[1] & g[0]);

endmodule

// File: rtl/pg_serial_add_ctrl.sv
// Digit-serial adder: one shared pg_slice2, LSB digit first, returns sum,
// carry-out and whole-word group propagate/generate.
//
// state | meaning
// IDLE  | waiting for start; operands captured when start is seen
// RUN   | one digit per clock through the slice, busy high
// DONE  | one-cycle done pulse, results already registered
module pg_serial_add_ctrl
  import pg_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             grp_p,
  output logic             grp_g
);

  localparam int DIGITS = WIDTH / DIGIT_W;
  localparam int IDX_W  = $clog2(DIGITS + 1);

  if ((WIDTH < 2) || ((WIDTH % 2) != 0)) begin : g_bad_width
    $error("pg_serial_add_ctrl: WIDTH must be even and >= 2");
  end

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [WIDTH-1:0]   res_q, res_d;
  logic [WIDTH-1:0]   sum_q, sum_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               carry_q, carry_d;
  logic               p_acc_q, p_acc_d;
  logic               g_acc_q, g_acc_d;
  logic               cout_q, cout_d;
  logic               grp_p_q, grp_p_d;
  logic               grp_g_q, grp_g_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic [DIGIT_W-1:0]       slc_s;
  logic                     slc_c2;
  logic                     slc_dp;
  logic                     slc_dg;
  logic [WIDTH+DIGIT_W-1:0] res_shift;

  pg_slice2 u_slice (
    .a  (a_q[DIGIT_W-1:0]),
    .b  (b_q[DIGIT_W-1:0]),
    .c  (carry_q),
    .s  (slc_s),
    .c2 (slc_c2),
    .dp (slc_dp),
    .dg (slc_dg)
  );

  // New sum digit enters from the MSB side; after DIGITS shifts digit 0 sits at the LSB.
  assign res_shift = {slc_s, res_q};

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    sum_d   = sum_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    p_acc_d = p_acc_q;
    g_acc_d = g_acc_q;
    cout_d  = cout_q;
    grp_p_d = grp_p_q;
    grp_g_d = grp_g_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          carry_d = cin;
          idx_d   = '0;
          p_acc_d = 1'b1;
          g_acc_d = 1'b0;
          res_d   = '0;
          busy_d  = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        a_d     = a_q >> DIGIT_W;
        b_d     = b_q >> DIGIT_W;
        carry_d = slc_c2;
        p_acc_d = slc_dp & p_acc_q;
        g_acc_d = slc_dg | (slc_dp & g_acc_q);
        res_d   = res_shift[WIDTH+DIGIT_W-1:DIGIT_W];
        idx_d   = idx_q + IDX_W'(1);
        if (idx_q == IDX_W'(DIGITS - 1)) begin
          sum_d   = res_d;
          cout_d  = slc_c2;
          grp_p_d = p_acc_d;
          grp_g_d = g_acc_d;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      sum_q   <= '0;
      idx_q   <= '0;
      carry_q <= 1'b0;
      p_acc_q <= 1'b0;
      g_acc_q <= 1'b0;
      cout_q  <= 1'b0;
      grp_p_q <= 1'b0;
      grp_g_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      sum_q   <= sum_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      p_acc_q <= p_acc_d;
      g_acc_q <= g_acc_d;
      cout_q  <= cout_d;
      grp_p_q <= grp_p_d;
      grp_g_q <= grp_g_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy  = busy_q;
  assign done  = done_q;
  assign sum   = sum_q;
  assign cout  = cout_q;
  assign grp_p = grp_p_q;
  assign grp_g = grp_g_q;

endmodule
